// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [DATA_W-1:0] merge_be(input logic [DATA_W-1:0] old_w,
                                                  input logic [DATA_W-1:0] new_w,
                                                  input logic [BE_W-1:0]   be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the CPU data port and the responder.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid_i;
  logic              req_ready_o;
  logic              req_we_i;
  logic [31:0]       req_addr_i;
  logic [DATA_W-1:0] req_wdata_i;
  logic [BE_W-1:0]   req_be_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );

endinterface

// File: rtl/dmem_bank.sv
// Single-port word bank with per-byte write enables and a registered read port.
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           acc_i,
  input  logic                           wr_i,
  input  logic                           rd_i,
  input  logic [BE_W-1:0]                be_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
  input  logic [DATA_W-1:0]              wdata_i,
  output logic [DATA_W-1:0]              rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clk_i) begin
    if (acc_i && wr_i) mem_q[idx_i] <= merge_be(mem_q[idx_i], wdata_i, be_i);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (acc_i) rdata_d = rd_i ? mem_q[idx_i] : '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, programmable wait states.
// Optional access fault checking is enabled by defining DMEM_ERR_CHECK_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  dmem_responder_if.slave  bus
);

  localparam int IDX_W    = $clog2(DEPTH_WORDS);
  localparam int LAT_M1_I = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [CNT_W-1:0] LAT_M1 = LAT_M1_I[CNT_W-1:0];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic              err_q, err_d;
  logic              enter_resp;

  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [BE_W-1:0]   acc_be;
  logic              acc_err;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          we_d    = bus.req_we_i;
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_wdata_i;
          be_d    = bus.req_be_i;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With zero wait states the access happens on the accept edge, so the
  // request must come straight from the bus rather than from the capture regs.
  always_comb begin
    acc_we    = (state_q == IDLE) ? bus.req_we_i    : we_q;
    acc_addr  = (state_q == IDLE) ? bus.req_addr_i  : addr_q;
    acc_wdata = (state_q == IDLE) ? bus.req_wdata_i : wdata_q;
    acc_be    = (state_q == IDLE) ? bus.req_be_i    : be_q;
  end

`ifdef DMEM_ERR_CHECK_EN
  assign acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= 30'(DEPTH_WORDS));
`else
  logic unused_addr_bits;
  assign acc_err          = 1'b0;
  assign unused_addr_bits = ^{acc_addr[31:IDX_W+2], acc_addr[1:0]};
`endif

  always_comb begin
    err_d = err_q;
    if (enter_resp) err_d = acc_err;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
    end
  end

  dmem_bank #(.DEPTH_WORDS(DEPTH_WORDS)) u_bank (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .acc_i   (enter_resp),
    .wr_i    (acc_we && !acc_err),
    .rd_i    (!acc_we && !acc_err),
    .be_i    (acc_be),
    .idx_i   (acc_addr[IDX_W+1:2]),
    .wdata_i (acc_wdata),
    .rdata_o (bus.rsp_rdata_o)
  );

  assign bus.req_ready_o = (state_q == IDLE);
  assign bus.rsp_valid_o = (state_q == RESP);
  assign bus.rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: vector table plus multi-cycle corner sequences.
module tb_dmem_responder;
  import dmem_pkg::*;

`ifdef DMEM_ERR_CHECK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid3, valid0, rdy3, rdy0, we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  dmem_responder_if bus3();
  dmem_responder_if bus0();

  assign bus3.req_valid_i = valid3;
  assign bus3.req_we_i    = we;
  assign bus3.req_addr_i  = addr;
  assign bus3.req_wdata_i = wdata;
  assign bus3.req_be_i    = be;
  assign bus3.rsp_ready_i = rdy3;
  assign bus0.req_valid_i = valid0;
  assign bus0.req_we_i    = we;
  assign bus0.req_addr_i  = addr;
  assign bus0.req_wdata_i = wdata;
  assign bus0.req_be_i    = be;
  assign bus0.rsp_ready_i = rdy0;

  dmem_responder #(.DEPTH_WORDS(128), .LATENCY(3)) u_l3 (
    .clk_i (clk), .rst_i (rst), .bus (bus3.slave)
  );
  dmem_responder #(.DEPTH_WORDS(128), .LATENCY(0)) u_l0 (
    .clk_i (clk), .rst_i (rst), .bus (bus0.slave)
  );

  function automatic vec_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] b, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = w; v.addr = a; v.wdata = d; v.be = b; v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic pop_compare(input string name);
    vec_t e;
    if (exp_q.size() == 0) begin
      timeout_fail({name, "_no_expected"});
      return;
    end
    e = exp_q.pop_front();
    check32({name, "_rdata"}, bus3.rsp_rdata_o, e.exp_rdata);
    check1({name, "_err"}, bus3.rsp_err_o, e.exp_err);
  endtask

  task automatic wait_ready3(output bit ok);
    int n = 0;
    while (bus3.req_ready_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    ok = (n < 50);
  endtask

  task automatic wait_rsp3(output bit ok);
    int n = 0;
    while (bus3.rsp_valid_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    ok = (n < 50);
  endtask

  task automatic run_txn(input vec_t v, input string name);
    bit ok;
    @(negedge clk);
    we = v.we; addr = v.addr; wdata = v.wdata; be = v.be; valid3 = 1'b1; rdy3 = 1'b0;
    wait_ready3(ok);
    if (!ok) begin timeout_fail({name, "_accept"}); valid3 = 1'b0; return; end
    @(posedge clk);
    exp_q.push_back(v);
    @(negedge clk);
    valid3 = 1'b0;
    wait_rsp3(ok);
    if (!ok) begin timeout_fail({name, "_rsp"}); void'(exp_q.pop_front()); return; end
    pop_compare(name);
    rdy3 = 1'b1;
    @(negedge clk);
    rdy3 = 1'b0;
  endtask

  task automatic lat0_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd);
    @(negedge clk);
    we = w; addr = a; wdata = d; be = 4'hF; valid0 = 1'b1; rdy0 = 1'b1;
    check1("l0_ready_before", bus0.req_ready_o, 1'b1);
    @(posedge clk);
    @(negedge clk);
    valid0 = 1'b0;
    check1("l0_valid_c1", bus0.rsp_valid_o, 1'b1);
    check1("l0_ready_c1", bus0.req_ready_o, 1'b0);
    check32("l0_rdata_c1", bus0.rsp_rdata_o, exp_rd);
    @(negedge clk);
    check1("l0_valid_c2", bus0.rsp_valid_o, 1'b0);
    check1("l0_ready_c2", bus0.req_ready_o, 1'b1);
    rdy0 = 1'b0;
  endtask

  initial begin
    bit ok;
    rst = 1'b1; valid3 = 1'b0; valid0 = 1'b0; rdy3 = 1'b0; rdy0 = 1'b0;
    we = 1'b0; addr = '0; wdata = '0; be = '0;
    #1;
    check1("rst_ready", bus3.req_ready_o, 1'b1);
    check1("rst_valid", bus3.rsp_valid_o, 1'b0);
    check32("rst_rdata", bus3.rsp_rdata_o, 32'h0);
    check1("rst_err", bus3.rsp_err_o, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    vecs.push_back(mk(1, 32'h010, 32'h12345678, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(1, 32'h020, 32'h11223344, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(1, 32'h020, 32'hAABBCCDD, 4'h5, 32'h0, 1'b0));
    vecs.push_back(mk(0, 32'h020, 32'h0,        4'h0, 32'h11BB33DD, 1'b0));
    vecs.push_back(mk(1, 32'h024, 32'h01020304, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(1, 32'h024, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0));
    vecs.push_back(mk(0, 32'h024, 32'h0,        4'h0, 32'h01020304, 1'b0));
    vecs.push_back(mk(1, 32'h028, 32'h00000000, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(1, 32'h028, 32'h55667788, 4'hA, 32'h0, 1'b0));
    vecs.push_back(mk(0, 32'h028, 32'h0,        4'h0, 32'h55007700, 1'b0));
    vecs.push_back(mk(0, 32'h22B, 32'h0,        4'h0, ERR_EN ? 32'h0 : 32'h55007700, ERR_EN));
    vecs.push_back(mk(1, 32'h000, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0));
    vecs.push_back(mk(1, 32'h200, 32'h5A5A5A5A, 4'hF, 32'h0, ERR_EN));
    vecs.push_back(mk(0, 32'h000, 32'h0,        4'h0, ERR_EN ? 32'hA5A5A5A5 : 32'h5A5A5A5A, 1'b0));
    vecs.push_back(mk(0, 32'h202, 32'h0,        4'h0, ERR_EN ? 32'h0 : 32'h5A5A5A5A, ERR_EN));
    vecs.push_back(mk(0, 32'h010, 32'h0,        4'h0, 32'h12345678, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end

    // Latency = 3: accept, then valid only in the 4th cycle, ready back in the 5th.
    @(negedge clk);
    we = 1'b0; addr = 32'h020; valid3 = 1'b1; rdy3 = 1'b1;
    check1("lat3_ready_before", bus3.req_ready_o, 1'b1);
    @(posedge clk);
    exp_q.push_back(mk(0, 32'h020, 32'h0, 4'h0, 32'h11BB33DD, 1'b0));
    @(negedge clk);
    valid3 = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge clk);
      check1($sformatf("lat3_valid_c%0d", k), bus3.rsp_valid_o, k == 4);
      check1($sformatf("lat3_ready_c%0d", k), bus3.req_ready_o, k == 5);
      if (k == 4 && bus3.rsp_valid_o === 1'b1) pop_compare("lat3");
    end
    rdy3 = 1'b0;

    // Latency = 0: store then load on the second instance.
    lat0_txn(1'b1, 32'h030, 32'hCAFEF00D, 32'h0);
    lat0_txn(1'b0, 32'h030, 32'h0, 32'hCAFEF00D);

    // Backpressure with a competing request held on the bus.
    @(negedge clk);
    we = 1'b0; addr = 32'h020; valid3 = 1'b1; rdy3 = 1'b0;
    wait_ready3(ok);
    if (!ok) timeout_fail("bp_accept");
    @(posedge clk);
    exp_q.push_back(mk(0, 32'h020, 32'h0, 4'h0, 32'h11BB33DD, 1'b0));
    @(negedge clk);
    we = 1'b1; wdata = 32'hFFFFFFFF; be = 4'hF;
    wait_rsp3(ok);
    if (!ok) timeout_fail("bp_rsp");
    for (int k = 0; k < 5; k++) begin
      check1($sformatf("bp_valid_%0d", k), bus3.rsp_valid_o, 1'b1);
      check1($sformatf("bp_ready_%0d", k), bus3.req_ready_o, 1'b0);
      check32($sformatf("bp_rdata_%0d", k), bus3.rsp_rdata_o, 32'h11BB33DD);
      @(negedge clk);
    end
    pop_compare("bp_final");
    rdy3 = 1'b1; valid3 = 1'b0;
    @(negedge clk);
    rdy3 = 1'b0;
    check1("bp_after_valid", bus3.rsp_valid_o, 1'b0);
    check1("bp_after_ready", bus3.req_ready_o, 1'b1);
    @(negedge clk);
    check1("bp_once_valid", bus3.rsp_valid_o, 1'b0);
    run_txn(mk(0, 32'h020, 32'h0, 4'h0, 32'h11BB33DD, 1'b0), "bp_no_store");

    // Reset asserted mid-WAIT drops the pending store.
    @(negedge clk);
    we = 1'b1; addr = 32'h010; wdata = 32'hDEADBEEF; be = 4'hF; valid3 = 1'b1;
    wait_ready3(ok);
    if (!ok) timeout_fail("rw_accept");
    @(posedge clk);
    @(negedge clk);
    valid3 = 1'b0;
    check1("rw_in_wait_ready", bus3.req_ready_o, 1'b0);
    check32("rw_pre_rdata", bus3.rsp_rdata_o, 32'h11BB33DD);
    #2 rst = 1'b1;
    #1;
    check1("rw_ready", bus3.req_ready_o, 1'b1);
    check1("rw_valid", bus3.rsp_valid_o, 1'b0);
    check32("rw_rdata", bus3.rsp_rdata_o, 32'h0);
    check1("rw_err", bus3.rsp_err_o, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check1("rw_no_rsp", bus3.rsp_valid_o, 1'b0);
    end
    run_txn(mk(0, 32'h010, 32'h0, 4'h0, 32'h12345678, 1'b0), "rw_reload");

    check32("scoreboard_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
